// File: rtl/mux_pkg.sv
// mux_pkg: shared state encoding and channel indices for the 2:1 stream mux and its demux counterpart
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } mux_state_t;

    // sel encoding on the wire; the demux side decodes the same values
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-request round-robin arbiter
//   req[1:0] in  : request per channel
//   ptr      in  : preferred channel when both request
//   gnt[1:0] out : one-hot grant, or zero when nothing requests
module rr_arb2
    import mux_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] && (!req[1] || ptr == CH0);
    assign gnt[1] = req[1] && (!req[0] || ptr == CH1);

endmodule

// File: rtl/stream_mux_2to1.sv
// stream_mux_2to1: packet-locked round-robin merge of two valid/ready streams onto one registered output
//   clk, rst_n                        : clock, async active-low reset
//   din0/valid0/last0 in, ready0 out  : channel 0 input stream
//   din1/valid1/last1 in, ready1 out  : channel 1 input stream
//   dout/valid_out/last_out/sel_out   : registered output beat, sel_out = source channel
//   ready_in in                       : downstream ready
module stream_mux_2to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din0,
    input  logic             valid0,
    input  logic             last0,
    output logic             ready0,
    input  logic [WIDTH-1:0] din1,
    input  logic             valid1,
    input  logic             last1,
    output logic             ready1,
    output logic [WIDTH-1:0] dout,
    output logic             valid_out,
    output logic             last_out,
    output logic             sel_out,
    input  logic             ready_in
);

    mux_state_t       state, state_nx;
    logic             ptr, ptr_nx;
    logic [1:0]       arb_gnt, gnt;
    logic             out_free, acc0, acc1, acc, k, last_k;
    logic [WIDTH-1:0] din_k;

    rr_arb2 u_arb (
        .req ({valid1, valid0}),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // Arbitration only matters in IDLE; a locked packet owns the output
    // even through its own valid bubbles.
    always_comb begin
        gnt = state == LOCK0 ? 2'b01 : state == LOCK1 ? 2'b10 : arb_gnt;
    end

    assign out_free = !valid_out || ready_in;
    // rst_n gates ready so nothing is accepted while reset is held
    assign ready0   = rst_n && out_free && gnt[0];
    assign ready1   = rst_n && out_free && gnt[1];
    assign acc0     = valid0 && ready0;
    assign acc1     = valid1 && ready1;
    assign acc      = acc0 || acc1;
    assign k        = acc1 ? CH1 : CH0;
    assign last_k   = k ? last1 : last0;
    assign din_k    = k ? din1 : din0;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (acc) begin
            state_nx = last_k ? IDLE : (k ? LOCK1 : LOCK0);
            ptr_nx   = last_k ? ~k : ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= CH0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            sel_out   <= CH0;
        end else if (acc) begin
            dout      <= din_k;
            valid_out <= 1'b1;
            last_out  <= last_k;
            sel_out   <= k;
        end else if (out_free) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_2to1.sv
// tb_stream_mux_2to1: table-driven directed bench for stream_mux_2to1
module tb_stream_mux_2to1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din0 = '0, din1 = '0, dout;
    logic       valid0 = 1'b0, last0 = 1'b0, ready0;
    logic       valid1 = 1'b0, last1 = 1'b0, ready1;
    logic       valid_out, last_out, sel_out;
    logic       ready_in = 1'b1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       v0, l0;
        logic [7:0] d0;
        logic       v1, l1;
        logic [7:0] d1;
        logic       rin;
        logic       r0, r1;
        logic       vo;
        logic [7:0] dout;
        logic       lo, so, ptr;
    } vec_t;

    vec_t vecs[$];

    stream_mux_2to1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din0      (din0),
        .valid0    (valid0),
        .last0     (last0),
        .ready0    (ready0),
        .din1      (din1),
        .valid1    (valid1),
        .last1     (last1),
        .ready1    (ready1),
        .dout      (dout),
        .valid_out (valid_out),
        .last_out  (last_out),
        .sel_out   (sel_out),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v0, l0, input logic [7:0] d0, input logic v1, l1,
                       input logic [7:0] d1, input logic rin, r0, r1, vo,
                       input logic [7:0] d, input logic lo, so, p);
        vec_t x;
        x = '{v0, l0, d0, v1, l1, d1, rin, r0, r1, vo, d, lo, so, p};
        vecs.push_back(x);
    endtask

    initial begin
        //  v0 l0 d0     v1 l1 d1     rin r0 r1 | vo dout  lo so ptr
        // single-beat packets from both channels alternate
        add(1, 1, 8'hA0, 1, 1, 8'hB1, 1, 1, 0, 1, 8'hA0, 1, 0, 1);
        add(1, 1, 8'hA0, 1, 1, 8'hB1, 1, 0, 1, 1, 8'hB1, 1, 1, 0);
        add(1, 1, 8'hA0, 1, 1, 8'hB1, 1, 1, 0, 1, 8'hA0, 1, 0, 1);
        add(1, 1, 8'hA0, 1, 1, 8'hB1, 1, 0, 1, 1, 8'hB1, 1, 1, 0);
        // channel 0 packet 11,12,13 locks out a waiting channel 1
        add(1, 0, 8'h11, 1, 1, 8'h55, 1, 1, 0, 1, 8'h11, 0, 0, 0);
        add(1, 0, 8'h12, 1, 1, 8'h55, 1, 1, 0, 1, 8'h12, 0, 0, 0);
        add(1, 1, 8'h13, 1, 1, 8'h55, 1, 1, 0, 1, 8'h13, 1, 0, 1);
        add(0, 0, 8'h00, 1, 1, 8'h55, 1, 0, 1, 1, 8'h55, 1, 1, 0);
        // channel 1 packet 21,22,23 with 4 cycles of backpressure
        add(0, 0, 8'h00, 1, 0, 8'h21, 1, 0, 1, 1, 8'h21, 0, 1, 0);
        add(1, 1, 8'h77, 1, 0, 8'h22, 0, 0, 0, 1, 8'h21, 0, 1, 0);
        add(1, 1, 8'h77, 1, 0, 8'h22, 0, 0, 0, 1, 8'h21, 0, 1, 0);
        add(1, 1, 8'h77, 1, 0, 8'h22, 0, 0, 0, 1, 8'h21, 0, 1, 0);
        add(1, 1, 8'h77, 1, 0, 8'h22, 0, 0, 0, 1, 8'h21, 0, 1, 0);
        add(1, 1, 8'h77, 1, 0, 8'h22, 1, 0, 1, 1, 8'h22, 0, 1, 0);
        // two-cycle bubble inside the channel 1 packet, channel 0 stays stalled
        add(1, 1, 8'h77, 0, 0, 8'h00, 1, 0, 1, 0, 8'h22, 0, 1, 0);
        add(1, 1, 8'h77, 0, 0, 8'h00, 1, 0, 1, 0, 8'h22, 0, 1, 0);
        add(1, 1, 8'h77, 1, 1, 8'h23, 1, 0, 1, 1, 8'h23, 1, 1, 0);
        add(1, 1, 8'h77, 0, 0, 8'h00, 1, 1, 0, 1, 8'h77, 1, 0, 1);
        // idle: nothing valid, ptr holds
        for (int i = 0; i < 5; i++)
            add(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'h77, 1, 0, 1);

        // reset state, with both channels already requesting
        valid0 = 1'b1; valid1 = 1'b1;
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ready0", ready0, 0);
        chk("rst_ready1", ready1, 0);
        chk("rst_ptr", dut.ptr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            {valid0, last0, din0} = {vecs[i].v0, vecs[i].l0, vecs[i].d0};
            {valid1, last1, din1} = {vecs[i].v1, vecs[i].l1, vecs[i].d1};
            ready_in = vecs[i].rin;
            #1;
            chk($sformatf("v%0d_ready0", i), ready0, vecs[i].r0);
            chk($sformatf("v%0d_ready1", i), ready1, vecs[i].r1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_out", i), valid_out, vecs[i].vo);
            chk($sformatf("v%0d_dout", i), dout, vecs[i].dout);
            chk($sformatf("v%0d_last_out", i), last_out, vecs[i].lo);
            chk($sformatf("v%0d_sel_out", i), sel_out, vecs[i].so);
            chk($sformatf("v%0d_ptr", i), dut.ptr, vecs[i].ptr);
            @(negedge clk);
        end

        // reset in the middle of a channel 0 packet
        valid0 = 1'b1; last0 = 1'b0; din0 = 8'h31;
        valid1 = 1'b0; ready_in = 1'b1;
        @(posedge clk);
        #1;
        chk("lock0_valid_out", valid_out, 1);
        chk("lock0_dout", dout, 8'h31);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_out", valid_out, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_last_out", last_out, 0);
        chk("mid_rst_sel_out", sel_out, 0);
        chk("mid_rst_ready0", ready0, 0);
        chk("mid_rst_ptr", dut.ptr, 0);
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b1; last1 = 1'b1; din1 = 8'h44;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", ready0, 0);
        chk("post_rst_ready1", ready1, 1);
        @(posedge clk);
        #1;
        chk("post_rst_valid_out", valid_out, 1);
        chk("post_rst_dout", dout, 8'h44);
        chk("post_rst_sel_out", sel_out, 1);
        chk("post_rst_last_out", last_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
